// File: rtl/freq_count_ctrl_if.sv
// freq_count_ctrl_if: control/bus bundle for the byte-frequency counting
// sequencer of the Huffman encoder.
//   slave  modport - used by freq_count_ctrl (run control in, status/bus out)
//   master modport - used by the encoder FSM / bench driving the sequencer
//   start, abort, base_addr, word_count    : run control from the encoder FSM
//   HREADY, rollover_flag                  : bus beat accept, histogram overflow
//   clear_hist, read_enable, addr          : read-buffer / bus side controls
//   words_done, busy, done, err            : progress and handshake status
//   stall_cycles                           : only with FREQ_COUNT_CTRL_STALL_CNT_EN
interface freq_count_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  word_count;
  logic                  HREADY;
  logic                  rollover_flag;
  logic                  clear_hist;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  words_done;
  logic                  busy;
  logic                  done;
  logic                  err;
`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
  logic [LEN_WIDTH-1:0]  stall_cycles;
`endif

  modport slave (
    input  start, abort, base_addr, word_count, HREADY, rollover_flag,
    output clear_hist, read_enable, addr, words_done, busy, done, err
`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport master (
    output start, abort, base_addr, word_count, HREADY, rollover_flag,
    input  clear_hist, read_enable, addr, words_done, busy, done, err
`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
    , input stall_cycles
`endif
  );
endinterface

// File: rtl/freq_count_ctrl.sv
// freq_count_ctrl: sequencer for the byte-frequency counting phase.
// Clears the histogram, then streams word_count words starting at base_addr
// into the read buffer (one word per HREADY beat), and reports done, or a
// sticky err if the read buffer signals a histogram bin rollover.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - freq_count_ctrl_if.slave (run control, bus side, status)
// Optional: define FREQ_COUNT_CTRL_STALL_CNT_EN to add bus.stall_cycles, a
// saturating count of READ cycles that saw HREADY=0.
module freq_count_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input logic              clk,
  input logic              reset,
  freq_count_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  clear_hist;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  words_done;
  logic                  busy;
  logic                  done;
  logic                  err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      remaining   <= '0;
      clear_hist  <= 1'b0;
      read_enable <= 1'b0;
      addr        <= '0;
      words_done  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      clear_hist <= 1'b0;
      done       <= 1'b0;
      case (state)
        // ERROR accepts a fresh start exactly like IDLE; abort only matters
        // in ERROR (it is a no-op in IDLE) and always beats start.
        S_IDLE, S_ERROR: begin
          if (bus.abort) begin
            if (state == S_ERROR) begin
              state <= S_IDLE;
              err   <= 1'b0;
            end
          end else if (bus.start) begin
            err        <= 1'b0;
            words_done <= '0;
            if (bus.word_count != '0) begin
              state      <= S_CLEAR;
              clear_hist <= 1'b1;
              busy       <= 1'b1;
              addr       <= bus.base_addr;
              remaining  <= bus.word_count;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (bus.abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bus.rollover_flag) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state       <= S_READ;
            read_enable <= 1'b1;
          end
        end
        S_READ: begin
          // Rollover is checked ahead of HREADY so a coinciding beat is dropped.
          if (bus.abort) begin
            state       <= S_IDLE;
            read_enable <= 1'b0;
            busy        <= 1'b0;
          end else if (bus.rollover_flag) begin
            state       <= S_ERROR;
            read_enable <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
          end else if (bus.HREADY) begin
            addr       <= addr + ADDR_WIDTH'(1);
            words_done <= words_done + LEN_WIDTH'(1);
            remaining  <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state       <= S_DONE;
              read_enable <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.clear_hist  = clear_hist;
  assign bus.read_enable = read_enable;
  assign bus.addr        = addr;
  assign bus.words_done  = words_done;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err;

`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
  logic                 launch;
  logic [LEN_WIDTH-1:0] stall_cycles;

  // Clearing on the launch edge makes the counter read zero during CLEAR.
  assign launch = ((state == S_IDLE) || (state == S_ERROR)) && bus.start &&
                  !bus.abort && (bus.word_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (launch) begin
      stall_cycles <= '0;
    end else if ((state == S_READ) && !bus.HREADY && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + LEN_WIDTH'(1);
    end
  end

  assign bus.stall_cycles = stall_cycles;
`endif

endmodule

// File: tb/tb_freq_count_ctrl.sv
// tb_freq_count_ctrl: randomized self-checking bench for freq_count_ctrl.
// Each run is described as a transaction (base, length, HREADY pattern,
// optional rollover/abort/start-while-busy cycle); the expected per-cycle
// outputs are derived from that description and the run's beat count.
module tb_freq_count_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  freq_count_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

  freq_count_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic        exp_err = 1'b0;
  int unsigned exp_wd = 0;
  bit          wd_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.start         = 1'b0;
    bus_if.abort         = 1'b0;
    bus_if.HREADY        = 1'b0;
    bus_if.rollover_flag = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input logic e_err, input logic e_done);
    chk({tag, ".busy"},  bus_if.busy, 32'd0);
    chk({tag, ".clear"}, bus_if.clear_hist, 32'd0);
    chk({tag, ".re"},    bus_if.read_enable, 32'd0);
    chk({tag, ".done"},  bus_if.done, {31'd0, e_done});
    chk({tag, ".err"},   bus_if.err, {31'd0, e_err});
    if (wd_known) chk({tag, ".wd"}, bus_if.words_done, exp_wd);
  endtask

  // One complete run. Indices j count READ cycles from 0; roll_at/abort_at/
  // poke_at select the READ cycle carrying that event (-1 = none).
  task automatic run_case(input logic [15:0] base, input int n, input int stall_pct,
                          input logic [31:0] pat, input int pat_len,
                          input int roll_at, input int abort_at, input int poke_at);
    int          beats = 0;
    int          stalls = 0;
    logic [15:0] ea;
    logic        rdy;
    @(negedge clk);
    check_quiet("pre", exp_err, 1'b0);
    bus_if.start      = 1'b1;
    bus_if.base_addr  = base;
    bus_if.word_count = 16'(n);
    @(negedge clk);
    drive_idle();
    bus_if.HREADY     = 1'($urandom_range(1));
    bus_if.base_addr  = 16'($urandom);
    bus_if.word_count = 16'($urandom);
    if (n == 0) begin
      wd_known = 1'b0;
      exp_err  = 1'b0;
      check_quiet("zero", 1'b0, 1'b1);
      bus_if.HREADY = 1'b0;
      return;
    end
    exp_err  = 1'b0;
    exp_wd   = 0;
    wd_known = 1'b1;
    chk("clr.clear", bus_if.clear_hist, 32'd1);
    chk("clr.busy",  bus_if.busy, 32'd1);
    chk("clr.re",    bus_if.read_enable, 32'd0);
    chk("clr.addr",  bus_if.addr, base);
    chk("clr.wd",    bus_if.words_done, 32'd0);
    chk("clr.err",   bus_if.err, 32'd0);
    chk("clr.done",  bus_if.done, 32'd0);
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      ea = base + 16'(beats);
      chk("rd.re",    bus_if.read_enable, 32'd1);
      chk("rd.busy",  bus_if.busy, 32'd1);
      chk("rd.addr",  bus_if.addr, ea);
      chk("rd.wd",    bus_if.words_done, beats);
      chk("rd.clear", bus_if.clear_hist, 32'd0);
      chk("rd.done",  bus_if.done, 32'd0);
      if (j < pat_len) rdy = pat[j];
      else rdy = (stalls >= 40) || (int'($urandom_range(99)) >= stall_pct);
      bus_if.HREADY        = rdy;
      bus_if.rollover_flag = (j == roll_at);
      bus_if.abort         = (j == abort_at);
      bus_if.start         = (j == poke_at);
      if (j == poke_at) begin
        bus_if.word_count = 16'd1;
        bus_if.base_addr  = ~base;
      end
      if (!rdy) stalls++;
      if (j == abort_at) begin
        @(negedge clk);
        drive_idle();
        exp_wd  = beats;
        exp_err = 1'b0;
        check_quiet("abort", 1'b0, 1'b0);
        return;
      end
      if (j == roll_at) begin
        @(negedge clk);
        drive_idle();
        exp_wd  = beats;
        exp_err = 1'b1;
        check_quiet("roll", 1'b1, 1'b0);
        return;
      end
      if (rdy) begin
        beats++;
        if (beats == n) begin
          @(negedge clk);
          drive_idle();
          exp_wd = n;
          ea = base + 16'(n);
          check_quiet("done", 1'b0, 1'b1);
          chk("done.addr", bus_if.addr, ea);
`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
          chk("done.stall", bus_if.stall_cycles, stalls);
`endif
          return;
        end
      end
    end
    chk("read_bound", beats, n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    bus_if.base_addr  = 16'h0010;
    bus_if.word_count = 16'd4;
    reset        = 1'b1;
    bus_if.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.clear", bus_if.clear_hist, 32'd0);
    chk("rst.re",    bus_if.read_enable, 32'd0);
    chk("rst.addr",  bus_if.addr, 32'd0);
    chk("rst.wd",    bus_if.words_done, 32'd0);
    chk("rst.busy",  bus_if.busy, 32'd0);
    chk("rst.done",  bus_if.done, 32'd0);
    chk("rst.err",   bus_if.err, 32'd0);
`ifdef FREQ_COUNT_CTRL_STALL_CNT_EN
    chk("rst.stall", bus_if.stall_cycles, 32'd0);
`endif
    reset = 1'b0;
    drive_idle();
    exp_wd   = 0;
    wd_known = 1'b1;
    @(negedge clk);
    check_quiet("post_rst", 1'b0, 1'b0);

    run_case(16'h0010, 4, 0, 32'hF, 4, -1, -1, -1);
    run_case(16'h0010, 3, 0, 32'h19, 5, -1, -1, -1);
    run_case(16'h1234, 0, 0, 32'h0, 0, -1, -1, -1);
    run_case(16'hFFFE, 3, 0, 32'h7, 3, -1, -1, -1);
    run_case(16'h0100, 8, 0, 32'hFF, 8, 2, -1, -1);
    run_case(16'h0100, 8, 0, 32'hFF, 8, -1, -1, -1);
    run_case(16'h0200, 6, 0, 32'h3F, 6, -1, 2, -1);
    run_case(16'h0300, 5, 30, 32'h0, 0, -1, -1, 1);

    // Abort out of ERROR clears err.
    run_case(16'h0400, 4, 0, 32'hF, 4, 0, -1, -1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    drive_idle();
    exp_err = 1'b0;
    check_quiet("err_abort", 1'b0, 1'b0);

    // abort and start together in IDLE: no run starts.
    bus_if.abort      = 1'b1;
    bus_if.start      = 1'b1;
    bus_if.word_count = 16'd3;
    @(negedge clk);
    drive_idle();
    check_quiet("abort_start", 1'b0, 1'b0);
    @(negedge clk);
    check_quiet("abort_start2", 1'b0, 1'b0);

    // Reset in the middle of a READ phase.
    bus_if.start      = 1'b1;
    bus_if.base_addr  = 16'h0040;
    bus_if.word_count = 16'd5;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.HREADY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    exp_wd  = 0;
    exp_err = 1'b0;
    chk("mrst.addr", bus_if.addr, 32'd0);
    check_quiet("mrst", 1'b0, 1'b0);
    @(negedge clk);
    check_quiet("mrst2", 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int n;
      int roll;
      int ab;
      int pk;
      n    = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
      roll = ($urandom_range(5) == 0) ? int'($urandom_range(n + 3)) : -1;
      ab   = ($urandom_range(5) == 0) ? int'($urandom_range(n + 3)) : -1;
      pk   = ($urandom_range(3) == 0) ? int'($urandom_range(n + 3)) : -1;
      run_case(16'($urandom), n, int'($urandom_range(60)), 32'h0, 0, roll, ab, pk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
